fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hold the PC and the IF/ID register.
REQ-005 SHALL have port flush  input  1  invalidate the instruction being latched into IF/ID.
REQ-006 SHALL have port redirect  input  1  load redirect_pc as the next PC (branch/jump taken).
REQ-007 SHALL have port redirect_pc  input  32  byte-address redirect target.
REQ-008 SHALL have port halt  input  1  stop fetching until reset.
REQ-009 SHALL have port imem_a  output  `MEMORY_ADDR_LEN  word address to instruction memory.
REQ-010 SHALL have port imem_rd  input  `WORD_LEN  instruction word returned combinationally by instruction memory.
REQ-011 SHALL have port pc  output  32  current fetch PC (byte address).
REQ-012 SHALL have port ifid_instr  output  `WORD_LEN  registered instruction for decode.
REQ-013 SHALL have port ifid_pc_plus4  output  32  registered PC+4 of ifid_instr.
REQ-014 SHALL have port ifid_valid  output  1  ifid_instr holds a real instruction.
REQ-015 SHALL have port fetch_count  output  32  count of valid instructions delivered (present only with FETCH_PERF_CNT_EN).

Function
REQ-016 SHALL drive imem_a = pc[`MEMORY_ADDR_LEN+1:2] combinationally; memory is word-addressed, so imem_a wraps modulo 2^`MEMORY_ADDR_LEN words.
REQ-017 SHALL implement FSM states BOOT, RUN and HALTED.
REQ-018 SHALL enter BOOT on reset; BOOT lasts exactly one cycle with no IF/ID load and no PC update, then moves to RUN.
REQ-019 In RUN, with stall=0 and no redirect/flush, each cycle SHALL load ifid_instr<=imem_rd, ifid_pc_plus4<=pc+4, ifid_valid<=1, and pc<=pc+4 (mod 2^32).
REQ-020 In RUN, redirect=1 SHALL load pc<={redirect_pc[31:2],2'b00} and ifid_valid<=0 regardless of stall.
REQ-021 In RUN, flush=1 without redirect SHALL load ifid_valid<=0, advance pc by 4 unless stall=1, and ignore stall for the valid clear.
REQ-022 In RUN, stall=1 without redirect or flush SHALL hold pc, ifid_instr, ifid_pc_plus4 and ifid_valid unchanged.
REQ-023 Priority SHALL be reset > redirect > flush > stall > halt > normal advance.
REQ-024 halt=1 in RUN (no redirect, no flush, no stall) SHALL move to HALTED, load ifid_valid<=0 and hold pc.
REQ-025 HALTED SHALL hold pc, keep ifid_valid=0 and ignore stall, flush, redirect and halt; only reset exits it.
REQ-026 Fetch-to-IF/ID latency SHALL be one cycle: instruction at pc in cycle N appears on ifid_instr after edge N+1.
REQ-027 ifid_instr and ifid_pc_plus4 SHALL NOT be updated when ifid_valid is cleared by flush, redirect or halt; only ifid_valid changes.

Reset
REQ-028 On reset the block SHALL set pc=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0 and state=BOOT.
REQ-029 Reset asserted mid-operation, including in HALTED or during stall, SHALL take effect at the next rising edge and override all other inputs.

Configuration
REQ-030 With macro FETCH_PERF_CNT_EN defined, the block SHALL provide fetch_count, reset it to 0 on reset, increment it by 1 (wrapping mod 2^32) on every edge that loads ifid_valid<=1, and hold it otherwise.
REQ-031 Without FETCH_PERF_CNT_EN, the fetch_count port and its counter logic SHALL be absent.

Verification
REQ-032 Reset, then release with the program image loaded (word0=20020005, word2=2067fff7) -> BOOT cycle ifid_valid=0; next edge ifid_instr=20020005, ifid_pc_plus4=4, ifid_valid=1; pc=8 after the second RUN edge.
REQ-033 Stall=1 for 3 cycles at pc=8 -> pc stays 8, ifid_* unchanged; after release ifid_instr=2067fff7, ifid_pc_plus4=0xC.
REQ-034 redirect=1 with redirect_pc=0x0000000E and stall=1 -> pc=0xC, ifid_valid=0; next edge ifid_instr=00e22025.
REQ-035 pc=0xFC (last word for 6-bit address) advanced -> imem_a=0 at pc=0x100; flush=1 on that edge -> ifid_valid=0, pc advances.
REQ-036 halt=1 in RUN, then redirect=1 -> stays HALTED, pc unchanged, ifid_valid=0; reset -> pc=RESET_PC; with FETCH_PERF_CNT_EN, fetch_count equals the number of valid loads and reads 0 after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with IF/ID pipeline register.
//
// Keeps the fetch PC, drives the word address to a combinational
// instruction memory and latches the returned word into the IF/ID
// register one cycle later.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold PC and IF/ID register
//   flush               invalidate the instruction being latched
//   redirect            load redirect_pc (word aligned) as the next PC
//   redirect_pc[31:0]   byte-address redirect target
//   halt                stop fetching until reset
//   imem_a              word address to instruction memory
//   imem_rd             instruction word from memory (combinational)
//   pc[31:0]            current fetch PC (byte address)
//   ifid_instr          registered instruction for decode
//   ifid_pc_plus4       registered PC+4 of ifid_instr
//   ifid_valid          ifid_instr holds a real instruction; decode may
//                       consume it on any edge where it is 1 (no ready,
//                       back-pressure is expressed through stall)
//   fetch_count[31:0]   valid instructions delivered (FETCH_PERF_CNT_EN only)
//   dbg_state[1:0]      FSM state, for observation only
//
// Optional feature: define FETCH_PERF_CNT_EN to build the fetch counter.

`ifndef MEMORY_ADDR_LEN
`define MEMORY_ADDR_LEN 6
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        redirect,
  input  logic [31:0]                 redirect_pc,
  input  logic                        halt,
  output logic [`MEMORY_ADDR_LEN-1:0] imem_a,
  input  logic [`WORD_LEN-1:0]        imem_rd,
  output logic [31:0]                 pc,
  output logic [`WORD_LEN-1:0]        ifid_instr,
  output logic [31:0]                 ifid_pc_plus4,
  output logic                        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                 fetch_count,
`endif
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [`WORD_LEN-1:0] instr_q, instr_d;
  logic [31:0]         pp4_q, pp4_d;
  logic                valid_q, valid_d;
  logic                load;      // IF/ID takes a new valid instruction

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      BOOT: begin
        // One idle cycle after reset: nothing is latched, PC holds.
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          // Redirect wins over stall: the wrong-path word is dropped.
          pc_d    = {redirect_pc[31:2], 2'b00};
          valid_d = 1'b0;
        end else if (flush) begin
          // Only the valid bit is cleared; the data fields keep their
          // previous contents.
          valid_d = 1'b0;
          if (!stall) pc_d = pc_plus4;
        end else if (stall) begin
          // hold everything
        end else if (halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          instr_d = imem_rd;
          pp4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
      HALTED: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pp4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_count = cnt_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

  assign imem_a        = pc_q[`MEMORY_ADDR_LEN+1:2];
  assign pc            = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pp4_q;
  assign ifid_valid    = valid_q;
  assign dbg_state     = state_q;

endmodule
